// File: rtl/ssd_scan_driver_pkg.sv
// Shared seven-segment font, blanking constants and decimal range helper
// for the scan display driver.
package ssd_scan_driver_pkg;

    typedef enum logic {
        MODE_DEC = 1'b0,
        MODE_HEX = 1'b1
    } dispMode_e;

    localparam logic [6:0] SEG_DASH = 7'b1111110;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    // Active-low {a,b,c,d,e,f,g}; b and d are drawn lowercase.
    function automatic logic [6:0] segFont(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            4'hF:    s = 7'b0111000;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/ssd_scan_driver_bin2bcd_seq.sv
// Sequential double-dabble converter: one input bit per cycle, done is
// asserted for the single cycle in which bcd holds the finished result.
module bin2bcd_seq #(
    parameter int VALUE_W    = 27,
    parameter int NUM_DIGITS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [VALUE_W-1:0]      value,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(VALUE_W + 1);

    logic [VALUE_W-1:0] shift_r;
    logic [BCD_W-1:0]   acc_r;
    logic [BCD_W-1:0]   adj_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               busy_r;

    // Add-3 correction on every BCD nibble that would exceed 9 after the shift.
    always_comb begin
        adj_s = acc_r;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            adj_s[4*i +: 4] = acc_r[4*i +: 4] + ((acc_r[4*i +: 4] >= 4'd5) ? 4'd3 : 4'd0);
        end
    end

    // Capture, shift VALUE_W times, then hold one done cycle before going idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= {VALUE_W{1'b0}};
            acc_r   <= {BCD_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
        end else if (start) begin
            shift_r <= value;
            acc_r   <= {BCD_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b1;
        end else if (busy_r && (cnt_r != CNT_W'(VALUE_W))) begin
            shift_r <= {shift_r[VALUE_W-2:0], 1'b0};
            acc_r   <= {adj_s[BCD_W-2:0], shift_r[VALUE_W-1]};
            cnt_r   <= cnt_r + CNT_W'(1);
            busy_r  <= 1'b1;
        end else begin
            shift_r <= shift_r;
            acc_r   <= acc_r;
            cnt_r   <= cnt_r;
            busy_r  <= 1'b0;
        end
    end

    assign busy = busy_r;
    assign done = busy_r && (cnt_r == CNT_W'(VALUE_W));
    assign bcd  = acc_r;

endmodule

// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment driver: hex/decimal load path with a one-deep
// pending buffer, leading-zero blanking, overflow dashes and anti-ghost slots.
module ssd_scan_driver
    import ssd_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int VALUE_W    = 27,
    parameter int SCAN_DIV   = 100000,
    parameter int BLANK_CYC  = 200
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [VALUE_W-1:0]    value,
    input  logic                  load,
    input  logic                  mode,
    input  logic                  blank_lz,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic                  busy,
    output logic                  overflow,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [6:0]            seg,
    output logic                  dp
);
    localparam int BCD_W  = 4 * NUM_DIGITS;
    localparam int EXT_W  = VALUE_W + BCD_W;
    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [63:0] DEC_LIMIT = pow10(NUM_DIGITS);

    logic [BCD_W-1:0]      digits_r;
    logic                  overflow_r;
    logic                  decOvfLatch_r;
    logic                  pendValid_r;
    logic [VALUE_W-1:0]    pendVal_r;
    dispMode_e             pendMode_r;
    logic [SLOT_W-1:0]     slotCnt_r;
    logic [IDX_W-1:0]      digitIdx_r;
    logic [NUM_DIGITS-1:0] anode_r;
    logic [6:0]            seg_r;
    logic                  dp_r;

    logic                  startReq_s;
    logic [VALUE_W-1:0]    startVal_s;
    dispMode_e             startMode_s;
    logic [EXT_W-1:0]      valExt_s;
    logic                  hexOvf_s;
    logic                  decOvf_s;
    logic                  engStart_s;
    logic                  engBusy_s;
    logic                  engDone_s;
    logic [BCD_W-1:0]      engBcd_s;
    logic [SLOT_W-1:0]     slotNext_s;
    logic [IDX_W-1:0]      idxNext_s;
    logic [NUM_DIGITS-1:0] shownMask_s;
    logic                  seenNz_s;
    logic [NUM_DIGITS-1:0] anodeNext_s;
    logic [6:0]            segNext_s;
    logic                  dpNext_s;

    // A fresh load wins over the pending entry; either starts only when idle.
    always_comb begin
        startReq_s = !engBusy_s && (load || pendValid_r);
        if (load) begin
            startVal_s  = value;
            startMode_s = dispMode_e'(mode);
        end else begin
            startVal_s  = pendVal_r;
            startMode_s = pendMode_r;
        end
        valExt_s   = EXT_W'(startVal_s);
        hexOvf_s   = |valExt_s[EXT_W-1:BCD_W];
        decOvf_s   = (64'(startVal_s) >= DEC_LIMIT);
        engStart_s = startReq_s && (startMode_s == MODE_DEC);
    end

    bin2bcd_seq #(
        .VALUE_W    (VALUE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (engStart_s),
        .value (startVal_s),
        .busy  (engBusy_s),
        .done  (engDone_s),
        .bcd   (engBcd_s)
    );

    // Digit registers, overflow flag and the one-deep pending load buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_r      <= {BCD_W{1'b0}};
            overflow_r    <= 1'b0;
            decOvfLatch_r <= 1'b0;
            pendValid_r   <= 1'b0;
            pendVal_r     <= {VALUE_W{1'b0}};
            pendMode_r    <= MODE_DEC;
        end else begin
            if (startReq_s && (startMode_s == MODE_HEX)) begin
                digits_r   <= valExt_s[BCD_W-1:0];
                overflow_r <= hexOvf_s;
            end else if (engDone_s) begin
                digits_r   <= engBcd_s;
                overflow_r <= decOvfLatch_r;
            end else begin
                digits_r   <= digits_r;
                overflow_r <= overflow_r;
            end
            if (engStart_s) begin
                decOvfLatch_r <= decOvf_s;
            end else begin
                decOvfLatch_r <= decOvfLatch_r;
            end
            if (load && engBusy_s) begin
                pendValid_r <= 1'b1;
                pendVal_r   <= value;
                pendMode_r  <= dispMode_e'(mode);
            end else if (startReq_s) begin
                pendValid_r <= 1'b0;
            end else begin
                pendValid_r <= pendValid_r;
            end
        end
    end

    // Next slot position, and which digits survive leading-zero blanking.
    always_comb begin
        slotNext_s  = slotCnt_r + SLOT_W'(1);
        idxNext_s   = digitIdx_r;
        if (slotCnt_r == SLOT_W'(SCAN_DIV - 1)) begin
            slotNext_s = {SLOT_W{1'b0}};
            if (digitIdx_r == IDX_W'(NUM_DIGITS - 1)) begin
                idxNext_s = {IDX_W{1'b0}};
            end else begin
                idxNext_s = digitIdx_r + IDX_W'(1);
            end
        end else begin
            idxNext_s = digitIdx_r;
        end
        seenNz_s    = 1'b0;
        shownMask_s = {NUM_DIGITS{1'b0}};
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            seenNz_s       = seenNz_s || (digits_r[4*i +: 4] != 4'd0);
            shownMask_s[i] = seenNz_s || (i == 0) || !blank_lz || overflow_r;
        end
    end

    // Pins are decoded from the slot being entered so they stay slot-aligned.
    always_comb begin
        anodeNext_s = {NUM_DIGITS{1'b1}};
        segNext_s   = SEG_OFF;
        dpNext_s    = 1'b1;
        if ((slotNext_s >= SLOT_W'(BLANK_CYC)) && shownMask_s[idxNext_s]) begin
            anodeNext_s[idxNext_s] = 1'b0;
            segNext_s = overflow_r ? SEG_DASH : segFont(digits_r[{idxNext_s, 2'b00} +: 4]);
            dpNext_s  = ~dp_mask[idxNext_s];
        end else begin
            anodeNext_s = {NUM_DIGITS{1'b1}};
            segNext_s   = SEG_OFF;
            dpNext_s    = 1'b1;
        end
    end

    // Slot counter, digit index and registered display pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slotCnt_r  <= {SLOT_W{1'b0}};
            digitIdx_r <= {IDX_W{1'b0}};
            anode_r    <= {NUM_DIGITS{1'b1}};
            seg_r      <= SEG_OFF;
            dp_r       <= 1'b1;
        end else begin
            slotCnt_r  <= slotNext_s;
            digitIdx_r <= idxNext_s;
            anode_r    <= anodeNext_s;
            seg_r      <= segNext_s;
            dp_r       <= dpNext_s;
        end
    end

    assign busy     = engBusy_s;
    assign overflow = overflow_r;
    assign anode    = anode_r;
    assign seg      = seg_r;
    assign dp       = dp_r;

endmodule

// File: doc/ssd_scan_driver.md
# ssd_scan_driver

Parametrised seven-segment scan driver for the board's eight-digit display; generalises the fixed four-digit counter display path. Takes a binary value from game logic (e.g. zombies killed), converts it to decimal with a sequential double-dabble engine or passes it through as hex, and drives time-multiplexed anodes and cathodes. Adds leading-zero blanking, overflow indication, per-digit decimal points, anti-ghosting blanking, and a one-deep pending-load buffer. Sits between game logic and the top-level An*/Ca..Cg/Dp pins.

## Interface
- NUM_DIGITS, 8, digits driven (1..8)
- VALUE_W, 27, input value width (≥4)
- SCAN_DIV, 100000, clk cycles per digit slot (≥ BLANK_CYC+2)
- BLANK_CYC, 200, cycles all anodes are off at the start of each slot
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- value  in  VALUE_W  binary value to display
- load  in  1  single-cycle request to capture value/mode
- mode  in  1  0 = decimal, 1 = hex; sampled with load
- blank_lz  in  1  1 = blank leading zeros (live, not latched)
- dp_mask  in  NUM_DIGITS  bit i lights DP of digit i (live)
- busy  out  1  decimal conversion in progress
- overflow  out  1  latched value not representable in NUM_DIGITS digits
- anode  out  NUM_DIGITS  active-low one-hot digit enable; digit 0 = rightmost
- seg  out  7  active-low {a,b,c,d,e,f,g}
- dp  out  1  active-low decimal point

## Operation
- Reset: anode all 1, seg 7'b1111111, dp 1, busy 0, overflow 0; digit registers, pending buffer, slot counter, digit index cleared.
- Idle load, mode=1: nibbles 0..NUM_DIGITS-1 of value go to the digit registers; overflow = any bit above 4*NUM_DIGITS set.
- Idle load, mode=0: value captured into shift register, BCD accumulator cleared, busy set; one bit shifted per cycle with add-3 correction on nibbles ≥5; after VALUE_W shifts the accumulator is copied to the digit registers. Overflow = captured value ≥ 10^NUM_DIGITS (constant compare at capture).
- Digit registers update atomically; the display never shows a partial conversion.
- load while busy: value/mode stored in pending buffer (latest wins, earlier pending discarded); started on the cycle busy falls.
- Overflow = 1: every enabled digit shows dash (seg 7'b1111110), DP per dp_mask.
- Scan: slot counter 0..SCAN_DIV-1; on wrap, index increments, wrapping NUM_DIGITS-1 → 0. While counter < BLANK_CYC anodes all 1.
- Leading-zero blanking (blank_lz=1, no overflow): digits above the most significant nonzero digit keep anode 1; digit 0 is always shown.
- Segment font: 0-9, A-F standard (b, d lowercase).

## Timing
- load sampled at edge E0. Hex: digit registers valid after E0+1, busy stays 0. Decimal: busy=1 after E0 through edge E0+VALUE_W+1, where registers and overflow update and busy falls together.
- Pending start: same edge busy falls; busy re-asserts next cycle, i.e. busy low for exactly 1 cycle.
- anode/seg/dp registered; change only on slot boundaries or digit-register updates.
- rst_n low mid-conversion: immediate reset, pending lost; first load after release behaves as from idle.

## Structure
- Shared package: seven-segment font function/constant table, SEG_DASH, SEG_OFF constants; 10^NUM_DIGITS constant function.
- Sub-module bin2bcd_seq (start/value/done/bcd) holding the double-dabble engine; scan, blanking and buffer logic stay in ssd_scan_driver.

## Test plan
Bench params NUM_DIGITS=4, VALUE_W=16, SCAN_DIV=4, BLANK_CYC=1.
- Reset held then released → anode 4'b1111, seg 7'b1111111, dp 1, busy 0 until first load.
- load 1234 decimal, blank_lz=0 → busy high 17 cycles; digits 1,2,3,4; during digit 0 slot seg=7'b1001100.
- load 7 decimal, blank_lz=1 → only anode[0] ever low, seg=7'b0001111; anodes 1..3 stay 1 over a full frame.
- load 12345 decimal → overflow=1, every digit seg=7'b1111110; subsequent load 9 clears overflow.
- mode=1 load 0xBEEF → digits B,E,E,F one cycle after load, busy never 1; digit 3 seg=7'b1100000.
- load 100, then 42 and 99 during busy → display 100, then 99, 42 never shown; busy low 1 cycle between conversions; rst_n pulse mid-second conversion → all outputs reset immediately.
